result_bus_arbiter: RTL and testbench
=====================================

Name: result_bus_arbiter

Overview:
- Shares the single result broadcast bus (valid / prn / value / inst_id) among NUM_FU functional units.
- Every issue queue and the register file snoop this bus for wakeup and writeback.
- Each FU has a small per-requester skid FIFO. A round-robin scheduler grants one entry per cycle onto a registered bus.
- FUs never stall mid-pipeline unless their own FIFO is full.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8)
- PRN_BITS, 6, physical register number width
- INST_ID_BITS, 6, instruction ID width
- SKID_DEPTH, 2, entries per requester FIFO (power of 2, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush, discards all buffered results
- req_valid[NUM_FU]  in  1 each  FU i presents a result
- req_prn[NUM_FU]  in  PRN_BITS each  destination PRN
- req_inst_id[NUM_FU]  in  INST_ID_BITS each  producing instruction ID
- req_value[NUM_FU]  in  64 each  result value
- req_ready[NUM_FU]  out  1 each  FU i FIFO can accept this cycle
- result_valid  out  1  broadcast valid
- result_prn  out  PRN_BITS  broadcast PRN
- result_inst_id  out  INST_ID_BITS  broadcast instruction ID
- result_value  out  64  broadcast value
- result_src  out  $clog2(NUM_FU)  index of granted FU

Behaviour:
- Reset (rst low, async):
  - all FIFOs empty
  - rr_ptr=0
  - result_valid=0; result_prn, result_inst_id, result_value and result_src all 0
  - req_ready=1 for every FU once reset deasserts
- Push: req_valid[i] && req_ready[i] at a clock edge writes FU i FIFO tail.
  - req_valid while req_ready=0 is ignored. The FU must hold its request.
- req_ready[i] = (count[i] < SKID_DEPTH).
  - It is a function of registered count only. There is no combinational path from req_valid or from the grant.
- Arbitration, every cycle:
  - candidates = FUs with a non-empty FIFO
  - The grant goes to the first candidate scanning from rr_ptr upward, wrapping at NUM_FU-1 -> 0.
  - On a grant to g, rr_ptr <= (g+1) mod NUM_FU. With no grant, rr_ptr holds.
- Broadcast:
  - The granted FIFO head is popped and registered onto the result_* outputs at the same edge.
  - result_valid=1 for exactly one cycle per entry.
  - With no candidate, result_valid=0 and the data outputs hold their previous values.
- Latency: a push at edge N into an empty FIFO with no contention is broadcast at edge N+1 (visible during cycle N+1). A push cannot bypass the FIFO within the same edge.
- Simultaneous push and pop on the same FIFO:
  - allowed
  - count unchanged
  - ordering preserved, FIFO order within one FU
- Full FIFO popped in the same cycle: req_ready is still 0 that cycle, since it is based on registered count. It rises the following cycle.
- Throughput: one broadcast per cycle total. A single FU alone reaches one result per cycle sustained.
- Fairness: with all FIFOs continuously non-empty, grants rotate 0,1,..,NUM_FU-1. No FU waits more than NUM_FU-1 cycles once its FIFO is non-empty.
- flush=1 at an edge:
  - all FIFO counts, heads and tails go to 0; result_valid <= 0
  - pushes in that cycle are discarded
  - rr_ptr is retained
- Reset mid-operation: buffered results are lost and result_valid drops immediately (async).
- Pointer and count arithmetic is modulo SKID_DEPTH with wrap-around. count uses $clog2(SKID_DEPTH)+1 bits.

Optional Feature:
- Macro: RESULT_BUS_ARB_PERF_EN
- Defined:
  - Adds ports perf_bcast_cnt (out, 32) and perf_stall_cnt (out, 32).
  - perf_bcast_cnt increments on every cycle with result_valid asserted.
  - perf_stall_cnt increments on every cycle where any req_valid[i] is high with req_ready[i] low.
  - Both reset to 0 on rst. flush does not clear them. They saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Reset then single push: FU2 pushes prn=5, id=9, value=64'hDEAD_BEEF at edge 1 -> cycle 2: result_valid=1, prn=5, inst_id=9, value=DEAD_BEEF, src=2; cycle 3: result_valid=0.
- Contention: FUs 0,1,3 push simultaneously with rr_ptr=0 -> broadcasts on three consecutive cycles with src=0,1,3; rr_ptr ends at 0.
- Backpressure, SKID_DEPTH=2: FU1 pushes 4 back-to-back while FU0 saturates the bus.
  - FU1 req_ready drops after its 2nd accepted push.
  - Order on the bus is preserved (values 1,2,3,4).
  - No entry is lost or duplicated.
- Fairness: all 4 FUs hold req_valid constantly for 40 cycles -> each src is granted exactly 10 times, in strict rotation.
- Flush: 3 entries buffered across FUs, flush pulsed one cycle -> result_valid=0 next cycle and stays 0; all req_ready=1; subsequent push broadcasts normally.
- Async reset mid-stream: rst asserted low between edges while result_valid=1 -> result_valid=0 immediately, without waiting for clk. With RESULT_BUS_ARB_PERF_EN, both perf counters read 0.

Source files
------------

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: shares one registered result broadcast bus among
// NUM_FU functional units. Each FU writes into its own small skid FIFO and a
// round-robin scheduler pops at most one FIFO head per cycle onto the bus.
//
// Optional build macro: RESULT_BUS_ARB_PERF_EN adds the perf_bcast_cnt and
// perf_stall_cnt saturating counters. Arbitration is identical either way.
//
// Handshake: an FU result is accepted at a rising edge when req_valid[i] and
// req_ready[i] are both high. req_ready[i] depends only on the registered
// FIFO count, so an FU seeing ready low must hold its request until a later
// edge. The result bus has no backpressure: result_valid is high for exactly
// one cycle per entry.
module result_bus_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int SKID_DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           req_valid,
  input  logic [PRN_BITS-1:0]         req_prn     [NUM_FU],
  input  logic [INST_ID_BITS-1:0]     req_inst_id [NUM_FU],
  input  logic [63:0]                 req_value   [NUM_FU],
  output logic [NUM_FU-1:0]           req_ready,
  output logic                        result_valid,
  output logic [PRN_BITS-1:0]         result_prn,
  output logic [INST_ID_BITS-1:0]     result_inst_id,
  output logic [63:0]                 result_value,
  output logic [$clog2(NUM_FU)-1:0]   result_src
`ifdef RESULT_BUS_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_bcast_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  localparam int SRC_W   = $clog2(NUM_FU);
  localparam int PTR_W   = $clog2(SKID_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PRN_BITS + INST_ID_BITS + 64;

  // Per-FU FIFO storage and bookkeeping; entries packed as {prn, id, value}.
  logic [ENTRY_W-1:0] mem   [NUM_FU][SKID_DEPTH];
  logic [PTR_W-1:0]   head  [NUM_FU];
  logic [PTR_W-1:0]   tail  [NUM_FU];
  logic [CNT_W-1:0]   count [NUM_FU];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;
  logic [SRC_W:0]     cand_sum;
  logic               grant_valid;
  logic [NUM_FU-1:0]  push;
  logic [NUM_FU-1:0]  pop;
  logic [ENTRY_W-1:0] head_entry;

  // Ready comes from registered occupancy only, never from valid or grant.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      req_ready[i] = (count[i] < CNT_W'(SKID_DEPTH));
    end
  end

  // Round-robin scan: first non-empty FIFO starting at rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand_sum >= (SRC_W+1)'(NUM_FU)) begin
        cand_sum = cand_sum - (SRC_W+1)'(NUM_FU);
      end
      cand = cand_sum[SRC_W-1:0];
      if (!grant_valid && (count[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_next    = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + SRC_W'(1);
    head_entry = mem[grant_idx][head[grant_idx]];
  end

  // Per-FU push/pop strobes; flush suppresses both so buffered work is dropped.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = req_valid[i] && req_ready[i] && !flush;
      pop[i]  = grant_valid && !flush && (grant_idx == SRC_W'(i));
    end
  end

  // FIFO data write at the tail; storage needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][tail[i]] <= {req_prn[i], req_inst_id[i], req_value[i]};
      end
    end
  end

  // FIFO pointers and counts; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) tail[i] <= tail[i] + PTR_W'(1);
        if (pop[i])  head[i] <= head[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Registered broadcast bus and round-robin pointer; flush keeps rr_ptr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_valid   <= 1'b0;
      result_prn     <= '0;
      result_inst_id <= '0;
      result_value   <= '0;
      result_src     <= '0;
      rr_ptr         <= '0;
    end else if (flush) begin
      result_valid   <= 1'b0;
    end else if (grant_valid) begin
      result_valid   <= 1'b1;
      {result_prn, result_inst_id, result_value} <= head_entry;
      result_src     <= grant_idx;
      rr_ptr         <= rr_next;
    end else begin
      result_valid   <= 1'b0;
    end
  end

`ifdef RESULT_BUS_ARB_PERF_EN
  logic any_stall;

  // A stall is any FU offering a result while its FIFO is full.
  always_comb begin
    any_stall = |(req_valid & ~req_ready);
  end

  // Saturating event counters; cleared only by reset, not by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bcast_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (result_valid && (perf_bcast_cnt != 32'hFFFF_FFFF)) begin
        perf_bcast_cnt <= perf_bcast_cnt + 32'd1;
      end
      if (any_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter: directed scenarios plus randomized traffic for
// result_bus_arbiter. A queue-based reference model predicts each broadcast;
// a monitor compares the bus against it every cycle.
// Optional build macro: RESULT_BUS_ARB_PERF_EN (perf counters also checked).
module tb_result_bus_arbiter;

  localparam int NUM_FU     = 4;
  localparam int PRN_BITS   = 6;
  localparam int ID_BITS    = 6;
  localparam int SKID_DEPTH = 2;
  localparam int DW         = PRN_BITS + ID_BITS + 64;
  localparam int EW         = DW + 2;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [NUM_FU-1:0]   drv_valid;
  logic [PRN_BITS-1:0] drv_prn [NUM_FU];
  logic [ID_BITS-1:0]  drv_id  [NUM_FU];
  logic [63:0]         drv_val [NUM_FU];
  logic [NUM_FU-1:0]   req_ready;
  logic                result_valid;
  logic [PRN_BITS-1:0] result_prn;
  logic [ID_BITS-1:0]  result_inst_id;
  logic [63:0]         result_value;
  logic [1:0]          result_src;
`ifdef RESULT_BUS_ARB_PERF_EN
  logic [31:0]         perf_bcast_cnt;
  logic [31:0]         perf_stall_cnt;
  int                  exp_bcast;
  int                  exp_stall;
`endif

  result_bus_arbiter #(
    .NUM_FU(NUM_FU), .PRN_BITS(PRN_BITS), .INST_ID_BITS(ID_BITS), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(drv_valid), .req_prn(drv_prn), .req_inst_id(drv_id), .req_value(drv_val),
    .req_ready(req_ready),
    .result_valid(result_valid), .result_prn(result_prn), .result_inst_id(result_inst_id),
    .result_value(result_value), .result_src(result_src)
`ifdef RESULT_BUS_ARB_PERF_EN
    , .perf_bcast_cnt(perf_bcast_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  logic [EW-1:0] exp_q [$];
  logic [DW-1:0] fu_q [NUM_FU][$];
  int            rr_model;
  logic          exp_valid;
  logic [NUM_FU-1:0] acc;
  int            n_checks;
  int            n_fail;
  logic          mon_en;
  logic          cnt_en;
  int            grant_cnt [NUM_FU];
  logic [1:0]    src_log [$];
  logic [63:0]   val_log [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) fu_q[i].delete();
    exp_q.delete();
    rr_model  = 0;
    exp_valid = 1'b0;
    acc       = '0;
`ifdef RESULT_BUS_ARB_PERF_EN
    exp_bcast = 0;
    exp_stall = 0;
`endif
  endtask

  // One clock cycle: called at a negedge with inputs set; predicts the next
  // edge from the model's queues, then advances to the following negedge.
  task automatic step(input logic fl);
    logic [NUM_FU-1:0] rdy;
    logic [DW-1:0]     e;
    flush = fl;
    for (int i = 0; i < NUM_FU; i++) begin
      rdy[i] = (fu_q[i].size() < SKID_DEPTH);
      check($sformatf("req_ready[%0d]", i), req_ready[i], rdy[i]);
    end
`ifdef RESULT_BUS_ARB_PERF_EN
    if (exp_valid) exp_bcast++;
    if ((drv_valid & ~rdy) != '0) exp_stall++;
`endif
    acc = '0;
    if (fl) begin
      for (int i = 0; i < NUM_FU; i++) fu_q[i].delete();
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
        int g;
        g = (rr_model + k) % NUM_FU;
        if (!exp_valid && fu_q[g].size() > 0) begin
          e = fu_q[g].pop_front();
          exp_q.push_back({e, 2'(g)});
          exp_valid = 1'b1;
          rr_model  = (g + 1) % NUM_FU;
        end
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (drv_valid[i] && rdy[i]) begin
          fu_q[i].push_back({drv_prn[i], drv_id[i], drv_val[i]});
          acc[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic offer(input int i, input logic [5:0] p, input logic [5:0] d, input logic [63:0] v);
    drv_valid[i] = 1'b1;
    drv_prn[i]   = p;
    drv_id[i]    = d;
    drv_val[i]   = v;
  endtask

  task automatic offer_rand(input int i, input int pct);
    drv_valid[i] = ($urandom_range(0, 99) < pct);
    drv_prn[i]   = 6'($urandom_range(0, 63));
    drv_id[i]    = 6'($urandom_range(0, 63));
    drv_val[i]   = {$urandom(), $urandom()};
  endtask

  task automatic idle(input int n);
    drv_valid = '0;
    repeat (n) step(1'b0);
  endtask

  // Monitor: compares the bus with the model prediction each cycle.
  always @(posedge clk) begin : monitor
    logic [EW-1:0] e;
    #1;
    if (mon_en) begin
      check("result_valid", result_valid, exp_valid);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bcast: unexpected broadcast src %0d value %0h", result_src, result_value);
        end else begin
          e = exp_q.pop_front();
          check("bcast", {result_prn, result_inst_id, result_value, result_src}, e);
        end
        src_log.push_back(result_src);
        if (result_src == 2'd1) val_log.push_back(result_value);
        if (cnt_en) grant_cnt[result_src]++;
      end
    end
  end

  // Test sequence
  initial begin : stimulus
    int sent1;
    logic [63:0] f0;
    flush     = 1'b0;
    drv_valid = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      drv_prn[i] = '0; drv_id[i] = '0; drv_val[i] = '0;
    end
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    cnt_en   = 1'b0;
    for (int i = 0; i < NUM_FU; i++) grant_cnt[i] = 0;
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", result_valid, 0);
    check("reset_data", {result_prn, result_inst_id, result_value, result_src}, 0);
    check("reset_ready", req_ready, 4'hF);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Single push from FU2: visible the cycle after the accepting edge.
    offer(2, 6'd5, 6'd9, 64'hDEAD_BEEF);
    step(1'b0);
    check("no_bypass", result_valid, 0);
    drv_valid = '0;
    step(1'b0);
    check("single_valid", result_valid, 1);
    check("single_data", {result_prn, result_inst_id, result_value}, {6'd5, 6'd9, 64'hDEAD_BEEF});
    check("single_src", result_src, 2);
    step(1'b0);
    check("single_one_cycle", result_valid, 0);

    // Bring the pointer back to 0 with a lone FU3 grant, then contend.
    offer(3, 6'd1, 6'd1, 64'h33);
    step(1'b0);
    idle(2);
    src_log.delete();
    offer(0, 6'd10, 6'd20, 64'h100);
    offer(1, 6'd11, 6'd21, 64'h101);
    offer(3, 6'd13, 6'd23, 64'h103);
    step(1'b0);
    idle(4);
    check("contend_count", src_log.size(), 3);
    if (src_log.size() == 3) begin
      check("contend_src0", src_log[0], 0);
      check("contend_src1", src_log[1], 1);
      check("contend_src2", src_log[2], 3);
    end
    src_log.delete();
    offer(0, 6'd2, 6'd2, 64'h200);
    offer(3, 6'd3, 6'd3, 64'h203);
    step(1'b0);
    idle(3);
    check("rr_back_to_0", (src_log.size() == 2) ? {src_log[0], src_log[1]} : 4'hF, 4'b0011);

    // Backpressure: FU0 floods, FU1 sends 1..4 and must hold when not ready.
    val_log.delete();
    sent1 = 0;
    f0    = 64'd100;
    offer(0, 6'd0, 6'd0, f0);
    offer(1, 6'd1, 6'd1, 64'd1);
    for (int c = 0; c < 40 && sent1 < 4; c++) begin
      step(1'b0);
      if (acc[0]) begin
        f0 = f0 + 64'd1;
        offer(0, 6'd0, 6'd0, f0);
      end
      if (acc[1]) begin
        sent1++;
        if (sent1 == 2) check("fu1_ready_after_2nd", req_ready[1], 0);
        if (sent1 < 4) offer(1, 6'd1, 6'(sent1), 64'(sent1 + 1));
        else drv_valid[1] = 1'b0;
      end
    end
    check("fu1_sent_all", sent1, 4);
    idle(10);
    check("fu1_count", val_log.size(), 4);
    for (int k = 0; k < 4 && k < val_log.size(); k++) begin
      check($sformatf("fu1_order[%0d]", k), val_log[k], k + 1);
    end

    // Fairness: all FUs request every cycle; 40 broadcasts in the window.
    for (int i = 0; i < NUM_FU; i++) offer(i, 6'(i), 6'(i), 64'(1000 * i));
    cnt_en = 1'b1;
    for (int c = 0; c < 41; c++) begin
      step(1'b0);
      for (int i = 0; i < NUM_FU; i++) begin
        if (acc[i]) drv_val[i] = drv_val[i] + 64'd1;
      end
    end
    cnt_en = 1'b0;
    idle(10);
    for (int i = 0; i < NUM_FU; i++) check($sformatf("fair_cnt[%0d]", i), grant_cnt[i], 10);

    // Flush with three buffered entries and a push in the flush cycle.
    offer(0, 6'd4, 6'd4, 64'h400);
    offer(1, 6'd5, 6'd5, 64'h401);
    offer(2, 6'd6, 6'd6, 64'h402);
    step(1'b0);
    drv_valid = '0;
    offer(3, 6'd7, 6'd7, 64'h403);
    step(1'b1);
    drv_valid = '0;
    check("flush_valid_next", result_valid, 0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0);
      check("flush_valid_stays", result_valid, 0);
    end
    check("flush_ready", req_ready, 4'hF);
    offer(1, 6'd8, 6'd8, 64'h500);
    step(1'b0);
    drv_valid = '0;
    step(1'b0);
    check("post_flush_valid", result_valid, 1);
    check("post_flush_src", result_src, 1);
    idle(2);

    // Asynchronous reset while a broadcast is on the bus.
    offer(0, 6'd9, 6'd9, 64'h600);
    offer(2, 6'd9, 6'd9, 64'h602);
    step(1'b0);
    drv_valid = '0;
    step(1'b0);
    check("pre_reset_valid", result_valid, 1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_reset_valid", result_valid, 0);
`ifdef RESULT_BUS_ARB_PERF_EN
    check("async_reset_bcast_cnt", perf_bcast_cnt, 0);
    check("async_reset_stall_cnt", perf_stall_cnt, 0);
`endif
    model_reset();
    @(negedge clk);
    check("reset_ready_again", req_ready, 4'hF);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < NUM_FU; i++) offer_rand(i, 50);
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_FU; i++) begin
        if (!drv_valid[i] || acc[i]) offer_rand(i, 20 + 20 * i);
      end
    end
    idle(12);
    check("drain_exp_q", exp_q.size(), 0);
`ifdef RESULT_BUS_ARB_PERF_EN
    check("perf_bcast_cnt", perf_bcast_cnt, exp_bcast);
    check("perf_stall_cnt", perf_stall_cnt, exp_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
